// File: rtl/vram_arbiter.sv
// vram_arbiter: shares single-port VRAM between CPU and VGA scanout with bounded CPU wait
module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic              CLK1_50,
  input  logic              RST_N,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        dbg_owner
);
  localparam logic [3:0] max_wait = 4'(CPU_MAX_WAIT);
  logic busy_v, busy_c, s1_valid, s1_owner, s2_valid, s2_owner;
  logic elig_v, elig_c, grant_v, grant_c;
  logic [3:0] cpu_wait;
  assign elig_v = vga_req & ~busy_v;
  assign elig_c = cpu_req & ~busy_c;
  assign grant_c = elig_c & (~elig_v | (cpu_wait == max_wait));
  assign grant_v = elig_v & ~grant_c;
  assign vga_valid = s2_valid & ~s2_owner;
  assign cpu_ack = s2_valid & s2_owner;
  assign vga_rdata = vga_valid ? ram_rdata : '0;
  assign cpu_rdata = cpu_ack ? ram_rdata : '0;
  assign dbg_owner = {s1_valid & s1_owner, s1_valid & ~s1_owner};
  // issue stage: register the winner's access; address/data hold when idle
  always_ff @(posedge CLK1_50 or negedge RST_N)
    if (!RST_N) begin
      ram_addr <= '0;
      ram_wdata <= '0;
      ram_we <= 1'b0;
      s1_valid <= 1'b0;
      s1_owner <= 1'b0;
    end else begin
      ram_addr <= grant_c ? cpu_addr : grant_v ? vga_addr : ram_addr;
      ram_wdata <= grant_c ? cpu_wdata : ram_wdata;
      ram_we <= grant_c & cpu_we;
      s1_valid <= grant_c | grant_v;
      s1_owner <= grant_c;
    end
  // completion stage: s2 drives the ack/valid pulses as RAM data arrives
  always_ff @(posedge CLK1_50 or negedge RST_N)
    if (!RST_N) begin
      s2_valid <= 1'b0;
      s2_owner <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_owner <= s1_owner;
    end
  // busy from grant until the end of the requester's ack cycle
  always_ff @(posedge CLK1_50 or negedge RST_N)
    if (!RST_N) begin
      busy_v <= 1'b0;
      busy_c <= 1'b0;
    end else begin
      busy_v <= grant_v | (busy_v & ~vga_valid);
      busy_c <= grant_c | (busy_c & ~cpu_ack);
    end
  // count eligible CPU cycles lost to VGA, saturating at the limit
  always_ff @(posedge CLK1_50 or negedge RST_N)
    if (!RST_N) cpu_wait <= '0;
    else cpu_wait <= (!elig_c || grant_c) ? 4'd0 : (cpu_wait == max_wait) ? cpu_wait : cpu_wait + 4'd1;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural RAM
module tb_vram_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic vga_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] vga_addr = '0, cpu_addr = '0, cpu_wdata = '0;
  logic vga_valid, cpu_ack, ram_we;
  logic [15:0] vga_rdata, cpu_rdata, ram_addr, ram_wdata, ram_rdata = '0;
  logic [1:0] dbg_owner;
  logic [15:0] mem [0:65535];
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {int cyc; logic [15:0] data; bit rd;} exp_t;
  exp_t cq[$], vq[$];

  vram_arbiter #(.ADDR_W(16), .DATA_W(16), .CPU_MAX_WAIT(4)) dut (
    .CLK1_50(clk), .RST_N(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .dbg_owner(dbg_owner)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // scoreboard monitor: every ack/valid must match the oldest expectation
  always @(negedge clk) if (rst_n) begin
    exp_t e;
    if (cpu_ack) begin
      n_chk++;
      if (cq.size() == 0) begin
        n_fail++;
        $display("FAIL cpu_ack unexpected at cycle %0d", cyc);
      end else begin
        e = cq.pop_front();
        if (e.cyc != cyc || (e.rd && cpu_rdata !== e.data)) begin
          n_fail++;
          $display("FAIL cpu_ack: cycle %0d data %h, expected cycle %0d data %h", cyc, cpu_rdata, e.cyc, e.data);
        end
      end
    end
    if (vga_valid) begin
      n_chk++;
      if (vq.size() == 0) begin
        n_fail++;
        $display("FAIL vga_valid unexpected at cycle %0d", cyc);
      end else begin
        e = vq.pop_front();
        if (e.cyc != cyc || vga_rdata !== e.data) begin
          n_fail++;
          $display("FAIL vga_valid: cycle %0d data %h, expected cycle %0d data %h", cyc, vga_rdata, e.cyc, e.data);
        end
      end
    end
  end

  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [15:0] wd, input logic [15:0] rd_exp);
    bit seen = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    cq.push_back('{cyc + 2, rd_exp, !we});
    @(negedge clk);
    chk("issue ram_we", 32'(ram_we), 32'(we));
    chk("issue ram_addr", 32'(ram_addr), 32'(addr));
    if (we) chk("issue ram_wdata", 32'(ram_wdata), 32'(wd));
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = cpu_ack;
    end
    chk("cpu_ack seen", 32'(seen), 32'd1);
    chk("ram_we low in ack cycle", 32'(ram_we), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[16'h0200 + i] = 16'hA000 + 16'(i * 17);
    mem[16'h0100] = 16'h5A5A;
    mem[16'h0020] = 16'h7777;
    repeat (3) @(negedge clk);
    chk("reset ram_we", 32'(ram_we), 32'd0);
    chk("reset ram_addr", 32'(ram_addr), 32'd0);
    chk("reset acks", {30'd0, cpu_ack, vga_valid}, 32'd0);
    chk("reset dbg_owner", 32'(dbg_owner), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    cpu_access(1'b1, 16'h0010, 16'hBEEF, 16'h0000);
    cpu_access(1'b0, 16'h0010, 16'h0000, 16'hBEEF);

    // continuous VGA scan, CPU idle: one fetch every third cycle
    vga_req = 1'b1; vga_addr = 16'h0200;
    for (int k = 0; k < 6; k++) vq.push_back('{cyc + 2 + 3 * k, 16'hA000 + 16'(k * 17), 1'b1});
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        chk("scan dbg_owner", 32'(dbg_owner), j == 0 ? 32'd1 : 32'd0);
        if (j == 1) begin
          if (k == 5) vga_req = 1'b0;
          else vga_addr = vga_addr + 16'd1;
        end
      end
    repeat (2) @(negedge clk);

    // both request together: VGA first, CPU next cycle, then they interleave
    vga_req = 1'b1; vga_addr = 16'h0100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    for (int k = 0; k < 3; k++) begin
      vq.push_back('{cyc + 2 + 3 * k, 16'h5A5A, 1'b1});
      cq.push_back('{cyc + 3 + 3 * k, 16'hBEEF, 1'b1});
    end
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        chk("shared dbg_owner", 32'(dbg_owner), j == 0 ? 32'd1 : j == 1 ? 32'd2 : 32'd0);
        if (k == 2 && j == 1) vga_req = 1'b0;
        if (k == 2 && j == 2) cpu_req = 1'b0;
      end
    repeat (2) @(negedge clk);

    // CPU drops req right after grant: access still completes once
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    cq.push_back('{cyc + 2, 16'hBEEF, 1'b1});
    @(negedge clk);
    chk("drop grant dbg_owner", 32'(dbg_owner), 32'd2);
    cpu_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("drop idle dbg_owner", 32'(dbg_owner), 32'd0);
    end

    // reset right after a write grant discards the write and its ack
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    cpu_req = 1'b0;
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst outputs", {ram_addr, ram_wdata}, 32'd0);
    chk("rst acks/dbg", {26'd0, dbg_owner, cpu_ack, vga_valid, 2'b00}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post-reset ram_we", 32'(ram_we), 32'd0);
    end
    chk("dropped write mem", 32'(mem[16'h0020]), 32'h7777);
    chk("cpu queue drained", 32'(cq.size()), 32'd0);
    chk("vga queue drained", 32'(vq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port video RAM between the CPU data port and the VGA scanout fetcher. Each cycle it grants at most one requester and issues that requester's access to the RAM. It returns read data with a fixed latency and a one-cycle acknowledge. It sits between the CPU core, the VGA timing/pixel unit and the on-chip VRAM block, and guarantees bounded CPU wait under continuous scanout.

## Interface
- ADDR_W, 16, RAM word-address width
- DATA_W, 16, RAM data width
- CPU_MAX_WAIT, 4, maximum consecutive cycles an eligible CPU request may lose to VGA (legal range 1..15)

Ports:
- CLK1_50  in  1  system clock, 50 MHz, all logic on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low (board KEY[0])
- vga_req  in  1  VGA read request, level, held until vga_valid
- vga_addr  in  ADDR_W  VGA read address, stable while vga_req
- vga_valid  out  1  one-cycle pulse: vga_rdata valid
- vga_rdata  out  DATA_W  read data, valid only with vga_valid
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle pulse: access complete; cpu_rdata valid for reads
- cpu_rdata  out  DATA_W  read data, valid only with cpu_ack on a read
- ram_addr  out  ADDR_W  registered RAM address
- ram_we  out  1  registered RAM write enable, one cycle per write
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_addr is presented
- dbg_owner  out  2  00 idle, 01 VGA, 10 CPU: owner of the access issued last cycle (drives OUT debug bus)

## Operation
- Each requester has a busy flag. eligible_x = x_req & !busy_x.
- Arbitration is combinational in cycle N:
  - VGA wins if eligible, unless CPU is eligible and cpu_wait == CPU_MAX_WAIT; then CPU wins.
  - If only one requester is eligible, it wins. If none, no issue.
- On issue, at the end of N: ram_addr, ram_we (= cpu_we for CPU, 0 for VGA), ram_wdata, s1_valid and s1_owner are registered, and busy_winner is set.
- When nothing is issued: ram_we=0, s1_valid=0; ram_addr and ram_wdata hold their previous values.
- Stage 2: s2_valid and s2_owner are registered from stage 1 at the end of N+1.
- Completion: in N+2, the owner's ack/valid is high (registered from s2). x_rdata = ram_rdata passthrough, valid during the ack cycle only.
- busy_x clears at the end of the ack cycle, so x is eligible again from N+3. A requester that saw its ack must drop req or present a new request by N+3.
- Writes follow the same pipeline. cpu_ack arrives in N+2; cpu_rdata is don't-care.
- Starvation counter cpu_wait (4 bits):
  - Increments when CPU is eligible and VGA wins.
  - Clears when CPU is granted or when CPU is not eligible.
  - Saturates at CPU_MAX_WAIT.
- At most one access in each stage. Both requesters may be in flight at once, in different stages.

## Timing
- Reset (RST_N low, asynchronous) clears: all outputs 0, busy flags, s1/s2 valid, cpu_wait, dbg_owner=00.
- In-flight accesses are discarded. No ack or valid is emitted for them after release, and a write already registered in stage 1 is dropped (ram_we forced 0).
- Latency: request visible in N → ack/valid in N+2. Per-requester throughput is 1 access per 3 cycles.
- Aggregate RAM throughput: up to 2 accesses per 3 cycles with both requesters continuously requesting.
- ram_we is high exactly one cycle per granted write, and never for VGA.
- Simultaneous first request from both: VGA issues in N, CPU issues in N+1 (VGA busy). CPU ack arrives in N+3.
- Requester changing address or we while req is high and not yet granted is legal; the value sampled at grant is used.
- Deasserting req while busy does not cancel the access; the ack is still produced.
- Address width wraps naturally. No range checking.

## Test plan
- CPU write addr 0x0010 data 0xBEEF, then read 0x0010 → ram_we high one cycle with ram_addr 0x0010. cpu_ack 2 cycles after each grant; read returns cpu_rdata 0xBEEF.
- VGA req held high with incrementing addresses, CPU idle → vga_valid every 3rd cycle. dbg_owner pattern 01,00,00; data matches preloaded RAM.
- vga_req and cpu_req rise in the same cycle N → VGA grant N, CPU grant N+1. vga_valid at N+2, cpu_ack at N+3.
- Two VGA masters modelled as continuous back-to-back VGA requests, with CPU_MAX_WAIT=4 and CPU requesting continuously → CPU loses at most 4 eligible cycles, then is granted. cpu_wait returns to 0.
- RST_N asserted the cycle after a CPU write grant → ram_we never high. No cpu_ack after release; all outputs 0 during reset.
- CPU drops cpu_req one cycle after grant → cpu_ack still pulses once at grant+2. No second access issued.
